// File: rtl/clk_strobe_gen_pkg.sv
// Shared types and helpers for the clk_strobe_gen strobe/divided-clock generator.
package clk_strobe_gen_pkg;

  typedef enum logic {ST_SETTLE, ST_LOCKED} state_t;

  // Channel-select width; a single-channel build still needs one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_strobe_chan.sv
// One output channel: divide/phase config, wrap counter and registered strobe/level decode.
module clk_strobe_chan #(
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 0,
  parameter int DEF_PHASE = 0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             outclk,
  output logic             outclk_en
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DEF_P = (DEF_PHASE > DEF_DIV) ? DIV_W'(DEF_DIV) : DIV_W'(DEF_PHASE);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] phase_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_wrap;
  logic [DIV_W:0]   half;

  // cnt_reg holds the count that the next run edge decodes; it is 0 through settle
  // so the lock edge always presents count 0.
  assign cnt_wrap = (cnt_reg == div_reg) ? '0 : cnt_reg + DIV_W'(1);
  assign half     = ({1'b0, div_reg} + (DIV_W+1)'(2)) >> 1;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div_reg   <= DEF_D;
      phase_reg <= DEF_P;
      cnt_reg   <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      if (load) begin
        div_reg   <= div;
        phase_reg <= (phase > div) ? div : phase;
      end
      if (clear) begin
        cnt_reg   <= '0;
        outclk    <= 1'b0;
        outclk_en <= 1'b0;
      end else if (run) begin
        outclk_en <= (cnt_reg == phase_reg);
        outclk    <= ({1'b0, cnt_reg} < half);
        cnt_reg   <= cnt_wrap;
      end
    end
  end

endmodule

// File: rtl/clk_strobe_gen.sv
// Runtime-programmable multi-channel divided strobe generator with a shared settle/lock FSM.
module clk_strobe_gen
  import clk_strobe_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 0,
  parameter int DEF_PHASE   = 0
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W-1:0]          cfg_phase,
  output logic                      cfg_err,
  output logic [NUM_CH-1:0]         outclk_en,
  output logic [NUM_CH-1:0]         outclk,
  output logic                      locked
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int SW   = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]   NUM_CH_V    = (CH_W+1)'(NUM_CH);

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic            transfer;
  logic            ch_ok;
  logic            valid_xfer;
  logic            settle_done;
  logic            locked_next;

  assign cfg_ready   = locked;
  assign transfer    = cfg_valid & locked;
  assign ch_ok       = ({1'b0, cfg_ch} < NUM_CH_V);
  assign valid_xfer  = transfer & ch_ok;
  assign settle_done = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  // Channels decode on the same edge that sets locked, so they key off its next value.
  assign locked_next = settle_done || ((state == ST_LOCKED) && !valid_xfer);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= transfer & ~ch_ok;
      case (state)
        ST_SETTLE: begin
          if (settle_done) begin
            state      <= ST_LOCKED;
            locked     <= 1'b1;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_LOCKED: begin
          if (valid_xfer) begin
            state      <= ST_SETTLE;
            locked     <= 1'b0;
            settle_cnt <= '0;
          end
        end
        default: begin
          state  <= ST_SETTLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic load_ch;
      assign load_ch = valid_xfer && (cfg_ch == CH_W'(gi));

      clk_strobe_chan #(
        .DIV_W     (DIV_W),
        .DEF_DIV   (DEF_DIV),
        .DEF_PHASE (DEF_PHASE)
      ) u_chan (
        .refclk    (refclk),
        .rst       (rst),
        .run       (locked_next),
        .clear     (~locked_next),
        .load      (load_ch),
        .div       (cfg_div),
        .phase     (cfg_phase),
        .outclk    (outclk[gi]),
        .outclk_en (outclk_en[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Randomised self-checking bench for clk_strobe_gen against a cycle-count reference model.
module tb_clk_strobe_gen;

  localparam int N  = 3;
  localparam int LC = 16;
  localparam int VW = 3 + 2 * N;

  logic           refclk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [7:0]     cfg_div = '0;
  logic [7:0]     cfg_phase = '0;
  logic           cfg_ready;
  logic           cfg_err;
  logic           locked;
  logic [N-1:0]   outclk_en;
  logic [N-1:0]   outclk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: configuration, edges since reset/reconfig, cycles since lock.
  int m_d [N];
  int m_p [N];
  int m_k;
  int m_settle;
  bit m_locked;
  bit m_err;
  bit m_xfer;

  clk_strobe_gen #(
    .NUM_CH(N), .DIV_W(8), .LOCK_CYCLES(LC), .DEF_DIV(0), .DEF_PHASE(0)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .outclk_en(outclk_en), .outclk(outclk), .locked(locked)
  );

  always #5 refclk = ~refclk;

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] e_clk;
    logic [N-1:0] e_en;
    for (int i = 0; i < N; i++) begin
      int c;
      c = m_k % (m_d[i] + 1);
      e_en[i]  = m_locked && (c == m_p[i]);
      e_clk[i] = m_locked && (c < (m_d[i] + 2) / 2);
    end
    return {m_locked, m_locked, m_err, e_clk, e_en};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {locked, cfg_ready, cfg_err, outclk, outclk_en};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_d[i] = 0;
      m_p[i] = 0;
    end
    m_k = 0; m_settle = 0; m_locked = 0; m_err = 0; m_xfer = 0;
  endtask

  // One rising edge; the model applies the rules to the inputs present at that edge.
  task automatic tick();
    @(posedge refclk);
    cyc++;
    m_err = 0;
    m_xfer = 0;
    if (!rst) begin
      if (m_locked && cfg_valid) begin
        if (int'(cfg_ch) < N) begin
          m_d[cfg_ch] = int'(cfg_div);
          m_p[cfg_ch] = (cfg_phase > cfg_div) ? int'(cfg_div) : int'(cfg_phase);
          m_locked = 0;
          m_settle = 0;
          m_xfer = 1;
        end else begin
          m_err = 1;
          m_k++;
        end
      end else if (m_locked) begin
        m_k++;
      end else begin
        m_settle++;
        if (m_settle == LC) begin
          m_locked = 1;
          m_k = 0;
        end
      end
    end
    #1;
  endtask

  task automatic drive_cfg(input bit v, input int ch, input int d, input int p);
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(d);
    cfg_phase = 8'(p);
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    total++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_lock();
    repeat (LC + 8) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL lock cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_reconfig();
    drive_cfg(1, 1, 3, 2);
    tick();
    drive_cfg(0, 0, 0, 0);
    total++;
    if (locked !== 1'b0) $display("FAIL reconfig_unlock cyc=%0d got %b want 0", cyc, locked);
    else passed++;
    repeat (LC + 14) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL reconfig cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_phase_clamp();
    drive_cfg(1, 2, 2, 7);
    tick();
    drive_cfg(0, 0, 0, 0);
    repeat (LC + 12) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL phase_clamp cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_invalid_ch();
    drive_cfg(1, 3, 9, 1);
    tick();
    drive_cfg(0, 0, 0, 0);
    total++;
    if ({cfg_err, locked} !== 2'b11) $display("FAIL invalid_err cyc=%0d got err=%b lock=%b want 1 1", cyc, cfg_err, locked);
    else passed++;
    repeat (10) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL invalid_ch cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_cfg_during_settle();
    bit seen;
    drive_cfg(1, 0, 1, 1);
    tick();
    drive_cfg(1, 0, 4, 3);
    seen = 0;
    for (int i = 0; i < LC + 8 && !seen; i++) begin
      tick();
      seen = m_xfer;
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL settle_hold cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
    drive_cfg(0, 0, 0, 0);
    total++;
    if (!seen) $display("FAIL settle_xfer cyc=%0d got no transfer want transfer", cyc);
    else passed++;
    repeat (LC + 12) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL settle_after cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_async cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
    else passed++;
    repeat (2) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_hold cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
    #2;
    rst = 1'b0;
    repeat (LC + 8) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_relock cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_random();
    repeat (500) begin
      int d;
      int p;
      d = $urandom_range(0, 9);
      if (d == 9) d = 255;
      p = $urandom_range(0, 15);
      if (p == 15) p = 255;
      drive_cfg($urandom_range(0, 15) == 0, $urandom_range(0, 3), d, p);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) $display("FAIL random cyc=%0d got %b want %b", cyc, dut_vec(), exp_vec());
      else passed++;
    end
    drive_cfg(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_reconfig();
    test_phase_clamp();
    test_invalid_ch();
    test_cfg_during_settle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_strobe_gen.md
# clk_strobe_gen

Parametrised, fully digital successor to the fixed-ratio clock wrapper in the SDRAM/camera clock tree. From a single reference clock, it generates NUM_CH phase-aligned, divided clock-enable strobes and registered divided clock levels. Each channel's divide ratio and phase are runtime-programmable through a valid/ready config port. A `locked` flag is re-earned after every reset or reconfiguration, and all channels restart aligned whenever `locked` rises.

## Interface

**Parameters**
- NUM_CH, 4: number of output channels (1..16).
- DIV_W, 8: width of the divide and phase fields.
- LOCK_CYCLES, 16: settle length in refclk cycles (≥1).
- DEF_DIV, 0: per-channel divide value loaded at reset.
- DEF_PHASE, 0: per-channel phase value loaded at reset.

**Ports**
- refclk, input, 1: the single clock.
- rst, input, 1: reset; asynchronous, active-high.
- cfg_valid, input, 1: config request.
- cfg_ready, output, 1: config accept; equals `locked`.
- cfg_ch, input, CH_W = max(1, clog2(NUM_CH)): target channel.
- cfg_div, input, DIV_W: divide value D; channel period is D+1 cycles.
- cfg_phase, input, DIV_W: phase value P.
- cfg_err, output, 1: one-cycle pulse when an accepted config has cfg_ch ≥ NUM_CH.
- outclk_en, output, NUM_CH: per-channel one-cycle strobe.
- outclk, output, NUM_CH: per-channel divided clock level.
- locked, output, 1: outputs valid and phase-aligned.

## Operation

**State machine**
- Two states: SETTLE and LOCKED.
- Reset enters SETTLE.
- SETTLE: a settle counter runs 0..LOCK_CYCLES-1. On the edge where it equals LOCK_CYCLES-1, the state moves to LOCKED.
- A successful valid config transfer in LOCKED moves the state to SETTLE and clears the settle counter.

**Handshake**
- A transfer occurs on a rising edge where cfg_valid and cfg_ready are both 1.
- cfg_ready is 0 throughout SETTLE. A held cfg_valid transfers on the first LOCKED cycle, which immediately re-enters SETTLE.

**Valid transfer (cfg_ch < NUM_CH)**
- Stores D = cfg_div and P' = min(cfg_phase, cfg_div) for the target channel.
- Every other channel keeps its configuration.
- All channels restart together on the next lock.

**Invalid transfer (cfg_ch ≥ NUM_CH)**
- Accepted and dropped: no state change, no configuration change, no counter disturbance.
- cfg_err is 1 for exactly the cycle after the accepting edge.

**Channel behaviour**
- k counts cycles since `locked` last rose, with k = 0 in the first locked cycle.
- Each channel's count is k mod (D+1).
- outclk_en[i] = (count == P').
- outclk[i] = (count < ((D+2)>>1)). This gives 50% duty for odd D+1 periods rounded high; D = 0 holds outclk at 1.

**Register and reset values**
- All outputs are registered.
- While not locked: outclk_en = 0, outclk = 0, channel counters are 0.
- Reset values: locked 0, cfg_ready 0, cfg_err 0, outclk 0, outclk_en 0, all channels D = DEF_DIV and P' = min(DEF_PHASE, DEF_DIV), settle counter 0.

## Timing

- After rst deasserts, `locked` is 1 after exactly LOCK_CYCLES rising edges.
- Channel outputs follow the count formulas from that same cycle (k = 0).
- On the accepting edge of a valid transfer, `locked`, cfg_ready, outclk and outclk_en all go to 0 at that edge. `locked` returns after LOCK_CYCLES further edges.
- rst asserted at any time clears all state and outputs immediately, without waiting for a clock edge. An in-flight settle is abandoned and configurations revert to their defaults.
- Divider counters wrap from D to 0 with no idle cycle. Counts are unsigned in DIV_W bits. D = 2^DIV_W − 1 is legal.

## Structure

- Package `clk_strobe_gen_pkg` holds:
  - the state enum {ST_SETTLE, ST_LOCKED};
  - the CH_W function.
- Sub-module `clk_strobe_chan` contains one channel's config registers, wrap counter, phase clamp and registered outclk/outclk_en decode. It has inputs run, clear, load, div and phase.
- The top instantiates `clk_strobe_chan` NUM_CH times via generate, alongside the shared settle FSM and config decode.

## Test plan

1. **Reset to lock (defaults D = 0):** release rst. Expect `locked` = 1 on the 16th edge, with outclk = 4'b1111 and outclk_en = 4'b1111 every cycle thereafter.
2. **Reconfigure channel 1:** write ch 1, D = 3, P = 2. Expect `locked` = 0 at the accepting edge and relock after 16 edges. Then outclk[1] = 1,1,0,0 repeating; outclk_en[1] high at k = 2, 6, 10; channel 0 unchanged at D = 0.
3. **Phase clamp:** write D = 2, P = 7. Expect the strobe at k = 2, 5, 8 and outclk pattern 1,1,0.
4. **Invalid channel (NUM_CH = 3):** write cfg_ch = 3. Expect a single-cycle cfg_err pulse, `locked` held at 1, and all channel patterns uninterrupted.
5. **Config during settle:** assert cfg_valid during SETTLE. Expect cfg_ready = 0 and no transfer. The transfer occurs on the first LOCKED cycle and settle restarts.
6. **Reset mid-operation:** assert rst between edges while locked with a reprogrammed channel. Expect all outputs 0 immediately. After release, expect defaults restored and `locked` after 16 edges.
